// File: rtl/struct_bus_arbiter_pkg.sv
// Shared types for the struct bus arbiter: the per-beat payload struct,
// the arbitration state enum and a small index helper.
package struct_bus_arbiter_pkg;

   localparam int MAX_REQ = 8;

   typedef struct packed {
      logic a;
      logic b;
   } StructA;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Successor of a requester index, wrapping n-1 back to 0.
   function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/struct_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted valid bit
// starting at the pointer and wrapping N_REQ-1 -> 0.
module struct_bus_arbiter_rr_pick
   import struct_bus_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W_ID  = 2
)
(
   input  logic [N_REQ-1:0] i_valid,
   input  logic [W_ID-1:0]  i_rr_ptr,
   output logic [W_ID-1:0]  o_pick,
   output logic             o_any
);

   int              idx;
   logic [W_ID-1:0] cand;

   // Scan offsets from farthest to nearest so the nearest valid bit wins.
   always_comb begin
      o_pick = '0;
      o_any  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = 32'(i_rr_ptr) + i;
         if (idx >= N_REQ) begin
            idx -= N_REQ;
         end
         cand = W_ID'(idx);
         if (i_valid[cand]) begin
            o_pick = cand;
            o_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/struct_bus_arbiter.sv
// N-way round-robin arbiter onto a single registered output slot carrying
// StructA beats. Define STRUCT_BUS_ARBITER_LOCK_EN to hold the grant on one
// requester for a whole burst (until its beat with last=1); without it every
// beat is arbitrated independently and i_req_last is ignored.
module struct_bus_arbiter
   import struct_bus_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W_ID  = 2
)
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [N_REQ-1:0]    i_req_valid,
   input  StructA [N_REQ-1:0]  i_req_payload,
   input  logic [N_REQ-1:0]    i_req_last,
   output logic [N_REQ-1:0]    o_req_ready,
   output logic                o_valid,
   output StructA              o_payload,
   output logic [W_ID-1:0]     o_grant_id,
   input  logic                i_ready
);

   if (W_ID != $clog2(N_REQ)) begin : g_bad_wid
      $error("struct_bus_arbiter: W_ID must equal $clog2(N_REQ)");
   end
   if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_nreq
      $error("struct_bus_arbiter: N_REQ must be in 2..8");
   end

   logic            valid_q, valid_d;
   StructA          payload_q, payload_d;
   logic [W_ID-1:0] id_q, id_d;
   logic [W_ID-1:0] rr_q, rr_d;

   logic [W_ID-1:0]  pick;
   logic             any_valid;
   logic             slot_free;
   logic             grant_en;
   logic [W_ID-1:0]  grant_id;
   logic [N_REQ-1:0] ready_comb;
   logic             accept;
   logic             rr_advance;

`ifdef STRUCT_BUS_ARBITER_LOCK_EN
   arb_state_e       state_q, state_d;
   logic [W_ID-1:0]  owner_q, owner_d;
`else
   logic             unused_last;
   assign unused_last = ^i_req_last;
`endif

   struct_bus_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .W_ID  (W_ID)
   ) u_pick (
      .i_valid  (i_req_valid),
      .i_rr_ptr (rr_q),
      .o_pick   (pick),
      .o_any    (any_valid)
   );

   assign slot_free = !valid_q || i_ready;

   // Choose who may be offered ready: the locked owner, else the round-robin pick.
   always_comb begin
      grant_en   = any_valid;
      grant_id   = pick;
      rr_advance = 1'b1;
`ifdef STRUCT_BUS_ARBITER_LOCK_EN
      if (state_q == LOCK) begin
         grant_en   = 1'b1;
         grant_id   = owner_q;
         rr_advance = i_req_last[owner_q];
      end
`endif
      ready_comb = '0;
      if (grant_en && slot_free && !i_rst) begin
         ready_comb[grant_id] = 1'b1;
      end
   end

   assign o_req_ready = ready_comb;
   assign accept      = i_req_valid[grant_id] && ready_comb[grant_id];

   // Output slot: load on accept, empty when drained with nothing new, else hold.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      id_d      = id_q;
      rr_d      = rr_q;
      if (accept) begin
         valid_d   = 1'b1;
         payload_d = i_req_payload[grant_id];
         id_d      = grant_id;
         if (rr_advance) begin
            rr_d = W_ID'(wrap_inc(32'(grant_id), 32'(N_REQ)));
         end
      end else if (slot_free) begin
         valid_d = 1'b0;
      end
   end

   // Slot and round-robin pointer registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         id_q      <= '0;
         rr_q      <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         id_q      <= id_d;
         rr_q      <= rr_d;
      end
   end

`ifdef STRUCT_BUS_ARBITER_LOCK_EN
   // Burst lock: enter on a non-last accept, leave on the owner's last beat.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (accept) begin
         case (state_q)
            ARB: begin
               if (!i_req_last[grant_id]) begin
                  state_d = LOCK;
                  owner_d = grant_id;
               end
            end
            LOCK: begin
               if (i_req_last[grant_id]) begin
                  state_d = ARB;
               end
            end
            default: state_d = ARB;
         endcase
      end
   end

   // Lock state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end
`endif

   assign o_valid    = valid_q;
   assign o_payload  = payload_q;
   assign o_grant_id = id_q;

endmodule

// File: tb/tb_struct_bus_arbiter.sv
// Self-checking bench for struct_bus_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_struct_bus_arbiter;
   import struct_bus_arbiter_pkg::*;

   localparam int N_REQ = 4;
   localparam int W_ID  = 2;
`ifdef STRUCT_BUS_ARBITER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic               i_clk;
   logic               i_rst;
   logic [N_REQ-1:0]   i_req_valid;
   StructA [N_REQ-1:0] i_req_payload;
   logic [N_REQ-1:0]   i_req_last;
   logic [N_REQ-1:0]   o_req_ready;
   logic               o_valid;
   StructA             o_payload;
   logic [W_ID-1:0]    o_grant_id;
   logic               i_ready;

   int checks = 0;
   int errors = 0;

   StructA           pay [N_REQ];
   logic [N_REQ-1:0] acc;
   logic [31:0]      dut_log [$];

   // reference model state
   bit               m_valid;
   StructA           m_payload;
   int               m_id;
   int               m_ptr;
   bit               m_locked;
   int               m_owner;
   logic [N_REQ-1:0] m_ready;
   int               m_grant;

   int exp_rr   [5] = '{0, 1, 2, 3, 0};
   int exp_lock [4] = '{1, 1, 1, 3};
   int exp_free [5] = '{1, 3, 1, 3, 1};

   bit               proto_check = 1'b0;
   logic [N_REQ-1:0] pend_q = '0;
   StructA           pend_pay [N_REQ];

   struct_bus_arbiter #(
      .N_REQ (N_REQ),
      .W_ID  (W_ID)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .i_req_payload (i_req_payload),
      .i_req_last    (i_req_last),
      .o_req_ready   (o_req_ready),
      .o_valid       (o_valid),
      .o_payload     (o_payload),
      .o_grant_id    (o_grant_id),
      .i_ready       (i_ready)
   );

   // Free-running clock.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Requester protocol: a pending beat stays valid with stable payload.
   always @(posedge i_clk) begin
      if (proto_check && !i_rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (pend_q[k]) begin
               assert (i_req_valid[k] && i_req_payload[k] == pend_pay[k])
                  else $error("[TB] requester %0d dropped or changed a pending beat", k);
            end
         end
      end
      pend_q <= i_req_valid & ~o_req_ready;
      for (int k = 0; k < N_REQ; k++) begin
         pend_pay[k] <= i_req_payload[k];
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void modelReset();
      m_valid   = 1'b0;
      m_payload = '0;
      m_id      = 0;
      m_ptr     = 0;
      m_locked  = 1'b0;
      m_owner   = 0;
   endfunction

   // Who is offered ready this cycle, and who (if anyone) is accepted.
   function automatic void modelComb();
      bit free;
      free    = !m_valid || i_ready;
      m_ready = '0;
      m_grant = -1;
      if (i_rst || !free) return;
      if (m_locked) begin
         m_ready[m_owner] = 1'b1;
         if (i_req_valid[m_owner]) m_grant = m_owner;
      end else begin
         for (int s = 0; s < N_REQ; s++) begin
            int k;
            k = (m_ptr + s) % N_REQ;
            if (i_req_valid[k]) begin
               m_ready[k] = 1'b1;
               m_grant    = k;
               break;
            end
         end
      end
   endfunction

   // Model update at the clock edge.
   function automatic void modelClock();
      if (i_rst) begin
         modelReset();
         return;
      end
      if (m_grant >= 0) begin
         m_valid   = 1'b1;
         m_payload = i_req_payload[m_grant];
         m_id      = m_grant;
         m_ptr     = (m_grant + 1) % N_REQ;
         if (LOCK_EN) begin
            if (!m_locked) begin
               if (!i_req_last[m_grant]) begin
                  m_locked = 1'b1;
                  m_owner  = m_grant;
               end
            end else if (i_req_last[m_grant]) begin
               m_locked = 1'b0;
            end
         end
      end else if (i_ready) begin
         m_valid = 1'b0;
      end
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] v,
                                input logic [N_REQ-1:0] l, input logic rdy);
      i_rst       = rst;
      i_req_valid = v;
      i_req_last  = l;
      i_ready     = rdy;
      for (int k = 0; k < N_REQ; k++) i_req_payload[k] = pay[k];
   endtask

   task automatic checkOutput();
      modelComb();
      checkVal("o_req_ready", 32'(o_req_ready), 32'(m_ready));
      checkVal("o_valid", 32'(o_valid), 32'(m_valid));
      checkVal("o_payload", 32'(o_payload), 32'(m_payload));
      checkVal("o_grant_id", 32'(o_grant_id), 32'(m_id));
      if (o_valid && i_ready && !i_rst) dut_log.push_back(32'(o_grant_id));
   endtask

   // One clock: check before the edge, advance the model on the edge.
   task automatic stepCycle();
      #1;
      checkOutput();
      acc = i_req_valid & o_req_ready;
      @(posedge i_clk);
      modelClock();
      @(negedge i_clk);
   endtask

   initial begin
      int b1;
      logic [N_REQ-1:0] rv, rl;
      logic rrst, rrdy;

      for (int k = 0; k < N_REQ; k++) pay[k] = StructA'(2'((k + 1) % 4));
      applyStimulus(1'b1, '1, '1, 1'b1);
      modelReset();
      @(negedge i_clk);

      // reset with every requester valid
      stepCycle();
      #1;
      checkVal("rst_ready", 32'(o_req_ready), 32'h0);
      checkVal("rst_valid", 32'(o_valid), 32'h0);
      stepCycle();

      // release: requester 0 first, then strict rotation
      applyStimulus(1'b0, '1, '1, 1'b1);
      #1;
      checkVal("first_ready", 32'(o_req_ready), 32'h1);
      dut_log.delete();
      repeat (6) stepCycle();
      checkVal("rr_len", 32'(dut_log.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++) checkVal($sformatf("rr_seq%0d", i), dut_log[i], 32'(exp_rr[i]));

      // backpressure with a beat from requester 2 in the slot
      applyStimulus(1'b0, 4'b0100, '1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 4'b1111, '1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         checkVal("bp_ready", 32'(o_req_ready), 32'h0);
         checkVal("bp_valid", 32'(o_valid), 32'h1);
         checkVal("bp_id", 32'(o_grant_id), 32'h2);
         checkVal("bp_payload", 32'(o_payload), 32'(pay[2]));
         stepCycle();
      end
      applyStimulus(1'b0, 4'b1011, '1, 1'b1);
      dut_log.delete();
      stepCycle();
      checkVal("bp_drain_id", dut_log[0], 32'h2);

      // burst from requester 1 competing with requester 3
      applyStimulus(1'b1, '0, '0, 1'b1);
      stepCycle();
      dut_log.delete();
      b1 = 0;
      for (int c = 0; c < 10; c++) begin
         rv = {1'b1, 1'b0, (b1 < 3), 1'b0};
         rl = {1'b1, 1'b0, (b1 == 2), 1'b0};
         applyStimulus(1'b0, rv, rl, 1'b1);
         stepCycle();
         if (acc[1]) b1++;
      end
`ifdef STRUCT_BUS_ARBITER_LOCK_EN
      for (int i = 0; i < 4; i++) checkVal($sformatf("lock_seq%0d", i), dut_log[i], 32'(exp_lock[i]));
`else
      for (int i = 0; i < 5; i++) checkVal($sformatf("free_seq%0d", i), dut_log[i], 32'(exp_free[i]));
`endif

      // reset mid-burst with the slot full
      applyStimulus(1'b1, '0, '0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0);
      #1;
      checkVal("mid_rst_ready", 32'(o_req_ready), 32'h0);
      stepCycle();
      #1;
      checkVal("mid_rst_valid", 32'(o_valid), 32'h0);
      applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b1);
      #1;
      checkVal("post_rst_ready", 32'(o_req_ready), 32'h8);
      stepCycle();
      checkVal("post_rst_id", 32'(o_grant_id), 32'h3);
      checkVal("post_rst_valid", 32'(o_valid), 32'h1);

      // randomized traffic
      rv = '0;
      rl = '0;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!rv[k] && $urandom_range(1, 0) == 1) begin
               rv[k]  = 1'b1;
               pay[k] = StructA'(2'($urandom_range(3, 0)));
               rl[k]  = ($urandom_range(2, 0) != 0);
            end
         end
         rrst = ($urandom_range(99, 0) == 0);
         rrdy = ($urandom_range(9, 0) < 7);
         applyStimulus(rrst, rv, rl, rrdy);
         stepCycle();
         for (int k = 0; k < N_REQ; k++) if (acc[k]) rv[k] = 1'b0;
         proto_check = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
